// File: rtl/button_ctrl_pkg.sv
// button_ctrl_pkg: shared mode constants, default parameter values and synchroniser depth
package button_ctrl_pkg;
   localparam logic MODE_KEY = 1'b0;
   localparam logic MODE_CMD = 1'b1;
   localparam int SYNC_STAGES = 2;
   localparam int DEF_NUM_KEYS = 4;
   localparam int DEF_NUM_SW = 3;
   localparam int DEF_DBNC_CNT_W = 2;
   localparam int DEF_RPT_DELAY = 25000000;
   localparam int DEF_RPT_PERIOD = 5000000;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: one-bit synchroniser plus debounce counter; output follows input after 2^DBNC_CNT_W differing samples
module input_debouncer
   import button_ctrl_pkg::*;
#(
   parameter int DBNC_CNT_W = DEF_DBNC_CNT_W
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic clean
);
   logic [SYNC_STAGES-1:0] sync;
   logic [DBNC_CNT_W-1:0] cnt;
   logic sync_out;
   assign sync_out = sync[SYNC_STAGES-1];
   // synchronise, then accept the new level only after it has differed for a full counter span
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync  <= '0;
         clean <= 1'b0;
         cnt   <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
         if (sync_out == clean) begin
            cnt <= '0;
         end else if (&cnt) begin
            clean <= sync_out;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/button_controller_multi.sv
// button_controller_multi: debounced keys/switches, mode routing and press pulses; BUTTON_CTRL_AUTO_REPEAT_EN adds key-plane hold-to-repeat
module button_controller_multi
   import button_ctrl_pkg::*;
#(
   parameter int NUM_KEYS   = DEF_NUM_KEYS,
   parameter int NUM_SW     = DEF_NUM_SW,
   parameter int DBNC_CNT_W = DEF_DBNC_CNT_W,
   parameter int RPT_DELAY  = DEF_RPT_DELAY,
   parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic [NUM_KEYS-1:0] KEY,
   input  logic [NUM_SW-1:0]   SW,
   output logic [NUM_KEYS-1:0] CleanButtonOut,
   output logic [NUM_SW-1:0]   CleanSWOut,
   output logic [NUM_KEYS-1:0] KEY_Reg,
   output logic [NUM_KEYS-1:0] CMD_Reg,
   output logic [NUM_KEYS-1:0] KEY_En,
   output logic [NUM_KEYS-1:0] CMD_En
);
   localparam int NCH = NUM_KEYS + NUM_SW;
   logic [NCH-1:0] raw, clean;
   logic [NUM_KEYS-1:0] btn_prev, rise, rpt;
   logic mode;
   if (NUM_KEYS < 1 || NUM_KEYS > 16 || NUM_SW < 1 || NUM_SW > 16 || RPT_DELAY < 2 || RPT_PERIOD < 2 || RPT_PERIOD >= RPT_DELAY) begin : g_param_check
      $error("button_controller_multi: parameter out of range");
   end
   // keys are active low on the board; invert so every channel is active high
   assign raw = {SW, ~KEY};
   for (genvar c = 0; c < NCH; c++) begin : g_dbnc
      input_debouncer #(.DBNC_CNT_W(DBNC_CNT_W)) u_dbnc (
         .clk    (CLOCK_50),
         .reset_n(RESET_N),
         .raw    (raw[c]),
         .clean  (clean[c])
      );
   end
   assign CleanButtonOut = clean[NUM_KEYS-1:0];
   assign CleanSWOut     = clean[NCH-1:NUM_KEYS];
   assign mode           = CleanSWOut[0];
   assign KEY_Reg        = (mode == MODE_KEY) ? CleanButtonOut : '0;
   assign CMD_Reg        = (mode == MODE_CMD) ? CleanButtonOut : '0;
   // only a fresh button edge pulses, so a mode flip under a held key stays silent
   assign rise = CleanButtonOut & ~btn_prev;
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
   localparam int RW = $clog2(RPT_DELAY + 1);
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rpt
      logic [RW-1:0] hold_cnt;
      assign rpt[k] = KEY_Reg[k] && (hold_cnt == RW'(RPT_DELAY));
      // zero means idle; armed to 1 by a key-plane press, reloaded so later repeats land RPT_PERIOD apart
      always_ff @(posedge CLOCK_50) begin
         if (!RESET_N || !KEY_Reg[k]) begin
            hold_cnt <= '0;
         end else if (rise[k]) begin
            hold_cnt <= RW'(1);
         end else if (rpt[k]) begin
            hold_cnt <= RW'(RPT_DELAY - RPT_PERIOD + 1);
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end
`else
   assign rpt = '0;
`endif
   // register edge history and the routed one-cycle enables
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         btn_prev <= '0;
         KEY_En   <= '0;
         CMD_En   <= '0;
      end else begin
         btn_prev <= CleanButtonOut;
         KEY_En   <= ((mode == MODE_KEY) ? rise : '0) | rpt;
         CMD_En   <= (mode == MODE_CMD) ? rise : '0;
      end
   end
endmodule

// File: tb/tb_button_controller_multi.sv
// tb_button_controller_multi: scoreboard bench for button_controller_multi (repeat checks follow BUTTON_CTRL_AUTO_REPEAT_EN)
module tb_button_controller_multi;
   localparam int W = 2;
   localparam int LAT = 2 + (1 << W);
   localparam int RD = 20;
   localparam int RP = 8;

   typedef struct {
      int         edge_no;
      logic [3:0] key_en;
      logic [3:0] cmd_en;
   } exp_t;

   logic clk = 1'b0;
   logic RESET_N;
   logic [3:0] KEY;
   logic [2:0] SW;
   logic [3:0] CleanButtonOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En;
   logic [2:0] CleanSWOut;

   int edge_n = 0;
   int checks = 0;
   int passes = 0;
   exp_t exp_q[$];

   button_controller_multi #(
      .NUM_KEYS(4), .NUM_SW(3), .DBNC_CNT_W(W), .RPT_DELAY(RD), .RPT_PERIOD(RP)
   ) dut (
      .CLOCK_50(clk), .RESET_N(RESET_N), .KEY(KEY), .SW(SW),
      .CleanButtonOut(CleanButtonOut), .CleanSWOut(CleanSWOut),
      .KEY_Reg(KEY_Reg), .CMD_Reg(CMD_Reg), .KEY_En(KEY_En), .CMD_En(CMD_En)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if ((|(KEY_En | CMD_En)) !== 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL pulse: unexpected at edge %0d key_en=%b cmd_en=%b, required no pulse", edge_n, KEY_En, CMD_En);
         end else begin
            e = exp_q.pop_front();
            if (edge_n !== e.edge_no || KEY_En !== e.key_en || CMD_En !== e.cmd_en)
               $display("FAIL pulse: got edge %0d key_en=%b cmd_en=%b, required edge %0d key_en=%b cmd_en=%b",
                        edge_n, KEY_En, CMD_En, e.edge_no, e.key_en, e.cmd_en);
            else
               passes++;
         end
      end
   end

   task automatic push(input int e, input logic [3:0] k, input logic [3:0] c);
      exp_t x;
      x.edge_no = e;
      x.key_en  = k;
      x.cmd_en  = c;
      exp_q.push_back(x);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      KEY = 4'hF;
      SW = 3'b000;
      cycles(3);
      checks++;
      if ({CleanButtonOut, CleanSWOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En} !== 23'd0)
         $display("FAIL reset_outputs: got %h, required 0", {CleanButtonOut, CleanSWOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En});
      else passes++;
      @(negedge clk) KEY = 4'b1101;
      cycles(10);
      checks++;
      if ({CleanButtonOut, CleanSWOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En} !== 23'd0)
         $display("FAIL reset_held_key: got %h, required 0", {CleanButtonOut, CleanSWOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En});
      else passes++;
      @(negedge clk) RESET_N = 1'b1;
      push(edge_n + 1 + LAT, 4'b0010, 4'b0000);
      cycles(8);
      checks++;
      if (CleanButtonOut !== 4'b0010) $display("FAIL reset_release_press: got %b, required 0010", CleanButtonOut);
      else passes++;
      @(negedge clk) KEY = 4'hF;
      cycles(12);
      checks++;
      if (exp_q.size() !== 0) $display("FAIL reset_release_pending: got %0d outstanding pulses, required 0", exp_q.size());
      else passes++;
      exp_q.delete();
   endtask

   task automatic test_key_press;
      @(negedge clk) KEY = 4'b1011;
      push(edge_n + 1 + LAT, 4'b0100, 4'b0000);
      cycles(5);
      checks++;
      if (CleanButtonOut !== 4'b0000) $display("FAIL key_press_early: got %b, required 0000", CleanButtonOut);
      else passes++;
      cycles(1);
      checks++;
      if ({CleanButtonOut, KEY_Reg, CMD_Reg} !== {4'b0100, 4'b0100, 4'b0000})
         $display("FAIL key_press_regs: got clean=%b key_reg=%b cmd_reg=%b, required 0100 0100 0000", CleanButtonOut, KEY_Reg, CMD_Reg);
      else passes++;
      @(negedge clk) KEY = 4'hF;
      cycles(12);
      checks++;
      if (exp_q.size() !== 0) $display("FAIL key_press_pending: got %0d outstanding pulses, required 0", exp_q.size());
      else passes++;
      exp_q.delete();
   endtask

   task automatic test_cmd_plane;
      @(negedge clk) SW = 3'b001;
      cycles(10);
      checks++;
      if (CleanSWOut !== 3'b001) $display("FAIL cmd_switch: got %b, required 001", CleanSWOut);
      else passes++;
      @(negedge clk) KEY = 4'b1110;
      push(edge_n + 1 + LAT, 4'b0000, 4'b0001);
      cycles(6);
      checks++;
      if ({CMD_Reg, KEY_Reg} !== {4'b0001, 4'b0000})
         $display("FAIL cmd_regs: got cmd_reg=%b key_reg=%b, required 0001 0000", CMD_Reg, KEY_Reg);
      else passes++;
      @(negedge clk) KEY = 4'hF;
      cycles(12);
      @(negedge clk) KEY = 4'b0111;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk) KEY = 4'hF;
      cycles(12);
      checks++;
      if (CleanButtonOut !== 4'b0000) $display("FAIL glitch: got %b, required 0000", CleanButtonOut);
      else passes++;
      checks++;
      if (exp_q.size() !== 0) $display("FAIL cmd_pending: got %0d outstanding pulses, required 0", exp_q.size());
      else passes++;
      exp_q.delete();
      @(negedge clk) SW = 3'b000;
      cycles(10);
   endtask

   task automatic test_mode_change;
      @(negedge clk) KEY = 4'b1101;
      push(edge_n + 1 + LAT, 4'b0010, 4'b0000);
      cycles(7);
      @(negedge clk) SW = 3'b001;
      cycles(5);
      checks++;
      if ({KEY_Reg, CMD_Reg} !== {4'b0010, 4'b0000})
         $display("FAIL mode_before: got key_reg=%b cmd_reg=%b, required 0010 0000", KEY_Reg, CMD_Reg);
      else passes++;
      cycles(1);
      checks++;
      if ({KEY_Reg, CMD_Reg} !== {4'b0000, 4'b0010})
         $display("FAIL mode_after: got key_reg=%b cmd_reg=%b, required 0000 0010", KEY_Reg, CMD_Reg);
      else passes++;
      cycles(10);
      @(negedge clk) KEY = 4'hF;
      cycles(12);
      @(negedge clk) SW = 3'b000;
      cycles(10);
      checks++;
      if (exp_q.size() !== 0) $display("FAIL mode_pending: got %0d outstanding pulses, required 0", exp_q.size());
      else passes++;
      exp_q.delete();
   endtask

   task automatic test_auto_repeat;
      int p;
      @(negedge clk) KEY = 4'b0111;
      p = edge_n + 1 + LAT;
      push(p, 4'b1000, 4'b0000);
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
      for (int i = 0; i < 4; i++) push(p + RD + i * RP, 4'b1000, 4'b0000);
`endif
      while (edge_n < p + 44) @(negedge clk);
      checks++;
      if (KEY_Reg !== 4'b1000) $display("FAIL repeat_held: got %b, required 1000", KEY_Reg);
      else passes++;
      KEY = 4'hF;
      cycles(40);
      checks++;
      if (exp_q.size() !== 0 || KEY_Reg !== 4'b0000)
         $display("FAIL repeat_release: got %0d outstanding pulses key_reg=%b, required 0 0000", exp_q.size(), KEY_Reg);
      else passes++;
      exp_q.delete();
   endtask

   task automatic test_simultaneous;
      @(negedge clk) KEY = 4'b0110;
      push(edge_n + 1 + LAT, 4'b1001, 4'b0000);
      cycles(8);
      @(negedge clk) KEY = 4'hF;
      cycles(12);
      checks++;
      if (exp_q.size() !== 0) $display("FAIL simultaneous_pending: got %0d outstanding pulses, required 0", exp_q.size());
      else passes++;
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_key_press();
      test_cmd_plane();
      test_mode_change();
      test_auto_repeat();
      test_simultaneous();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
